// File: rtl/hsync_if.sv
// ---------------------------------------------------------------------------
// hsync_if
//   Bundles the horizontal-sync monitor's pin and its recovered timing outputs.
//
//   VGA_HSYNC    incoming horizontal sync, active low, asynchronous to clk
//   locked       timing locked; HPIXEL/pixel_valid meaningful only when 1
//   HPIXEL       recovered pixel column 0..127
//   pixel_valid  high during the active display window while locked
//   line_period  last measured period (falling edge to falling edge)
//   pulse_width  last measured sync-low width
//   sync_error   one-cycle pulse on an out-of-spec line or a timeout
//
//   master : the monitor (samples VGA_HSYNC, drives the timing outputs)
//   slave  : the line source / capture side (drives VGA_HSYNC, reads timing)
// ---------------------------------------------------------------------------
interface hsync_if;
    logic        VGA_HSYNC;
    logic        locked;
    logic [6:0]  HPIXEL;
    logic        pixel_valid;
    logic [10:0] line_period;
    logic [10:0] pulse_width;
    logic        sync_error;

    modport master (
        input  VGA_HSYNC,
        output locked, HPIXEL, pixel_valid, line_period, pulse_width, sync_error
    );

    modport slave (
        output VGA_HSYNC,
        input  locked, HPIXEL, pixel_valid, line_period, pulse_width, sync_error
    );
endinterface

// File: rtl/hsync_monitor.sv
// ---------------------------------------------------------------------------
// hsync_monitor
//   Receive-side checker for VGA horizontal timing. Synchronises the incoming
//   active-low sync, measures line period and sync-low width, locks after
//   LOCK_LINES consecutive in-tolerance lines and then regenerates the pixel
//   column (HPIXEL) and the active-window flag (pixel_valid).
//
//   clk    system clock
//   reset  asynchronous, active-high reset
//   hsync  hsync_if.master: VGA_HSYNC in; locked, HPIXEL, pixel_valid,
//          line_period, pulse_width, sync_error out
// ---------------------------------------------------------------------------
module hsync_monitor #(
    parameter int LINE_CYCLES      = 1600,
    parameter int PULSE_CYCLES     = 192,
    parameter int BACK_PORCH       = 96,
    parameter int DISPLAY_CYCLES   = 1280,
    parameter int CYCLES_PER_PIXEL = 10,
    parameter int TOLERANCE        = 2,
    parameter int LOCK_LINES       = 4
) (
    input  logic    clk,
    input  logic    reset,
    hsync_if.master hsync
);
    localparam logic [11:0] CNT_MAX   = 12'hFFF;
    localparam logic [11:0] PER_MIN   = 12'(LINE_CYCLES - TOLERANCE);
    localparam logic [11:0] PER_MAX   = 12'(LINE_CYCLES + TOLERANCE);
    localparam logic [11:0] PW_MIN    = 12'(PULSE_CYCLES - TOLERANCE);
    localparam logic [11:0] PW_MAX    = 12'(PULSE_CYCLES + TOLERANCE);
    localparam logic [11:0] TIMEOUT   = 12'(LINE_CYCLES + TOLERANCE + 1);
    localparam logic [11:0] WIN_START = 12'(PULSE_CYCLES + BACK_PORCH);
    localparam logic [11:0] WIN_END   = 12'(PULSE_CYCLES + BACK_PORCH + DISPLAY_CYCLES - 1);
    localparam logic [3:0]  SUB_LAST  = 4'(CYCLES_PER_PIXEL - 1);
    localparam logic [2:0]  GOOD_LAST = 3'(LOCK_LINES - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state;
    logic        sync1, sync2, sync3;
    logic        fall_strb, rise_strb;
    logic [11:0] cnt, cnt_nxt, pw_cap;
    logic        rise_seen;
    logic [2:0]  good_cnt;
    logic [3:0]  sub_cnt;
    logic        line_good, timeout, in_window;

    function automatic logic [10:0] clip11(input logic [11:0] v);
        return v[11] ? 11'h7FF : v[10:0];
    endfunction

    // Synchroniser idles high so reset never manufactures a falling edge.
    // Strobes are registered: they appear 3 clk after the pin edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync3     <= 1'b1;
            fall_strb <= 1'b0;
            rise_strb <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample its
            // pre-edge input, which is what turns this into a shift chain.
            sync1     <= hsync.VGA_HSYNC;
            sync2     <= sync1;
            sync3     <= sync2;
            fall_strb <= sync3 & ~sync2;
            rise_strb <= ~sync3 & sync2;
        end
    end

    // cnt counts cycles since the last fall strobe. It is loaded with 1 after
    // the strobe so that, in the strobe cycle itself, it still holds the
    // length of the line that just finished.
    always_comb begin
        // NOTE: every combinational output gets a value on every path,
        // so no latch can be inferred.
        cnt_nxt = cnt + 12'd1;
        if (fall_strb)
            cnt_nxt = 12'd1;
        else if (cnt == CNT_MAX)
            cnt_nxt = cnt;
    end

    assign line_good = rise_seen && (cnt >= PER_MIN) && (cnt <= PER_MAX)
                       && (pw_cap >= PW_MIN) && (pw_cap <= PW_MAX);
    // A fall strobe on the timeout cycle takes precedence.
    assign timeout   = (cnt == TIMEOUT) && !fall_strb;
    assign in_window = (cnt_nxt >= WIN_START) && (cnt_nxt <= WIN_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            pw_cap    <= '0;
            rise_seen <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (fall_strb) begin
                rise_seen <= 1'b0;
            end else if (rise_strb && !rise_seen) begin
                rise_seen <= 1'b1;
                pw_cap    <= cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= SEARCH;
            good_cnt          <= '0;
            sub_cnt           <= '0;
            hsync.locked      <= 1'b0;
            hsync.HPIXEL      <= '0;
            hsync.pixel_valid <= 1'b0;
            hsync.line_period <= '0;
            hsync.pulse_width <= '0;
            hsync.sync_error  <= 1'b0;
        end else begin
            hsync.sync_error <= 1'b0;
            case (state)
                SEARCH: begin
                    if (fall_strb)
                        state <= MEASURE;
                end
                MEASURE, LOCKED: begin
                    if (fall_strb) begin
                        hsync.line_period <= clip11(cnt);
                        hsync.pulse_width <= clip11(pw_cap);
                        if (line_good) begin
                            if (state == MEASURE) begin
                                good_cnt <= good_cnt + 3'd1;
                                if (good_cnt == GOOD_LAST) begin
                                    state        <= LOCKED;
                                    hsync.locked <= 1'b1;
                                end
                            end
                        end else begin
                            // This edge already starts the next line.
                            good_cnt         <= '0;
                            hsync.sync_error <= 1'b1;
                            hsync.locked     <= 1'b0;
                            state            <= MEASURE;
                        end
                    end else if (timeout) begin
                        good_cnt         <= '0;
                        hsync.sync_error <= 1'b1;
                        hsync.locked     <= 1'b0;
                        state            <= SEARCH;
                    end
                end
                default: state <= SEARCH;
            endcase

            // Pixel window tracks cnt_nxt so the registered outputs line up
            // with cnt. Leaving LOCKED always coincides with cnt_nxt outside
            // the window (1 after a bad edge, past the end on timeout).
            if (state == LOCKED && in_window) begin
                hsync.pixel_valid <= 1'b1;
                if (!hsync.pixel_valid) begin
                    hsync.HPIXEL <= '0;
                    sub_cnt      <= '0;
                end else if (sub_cnt == SUB_LAST) begin
                    hsync.HPIXEL <= hsync.HPIXEL + 7'd1;
                    sub_cnt      <= '0;
                end else begin
                    sub_cnt <= sub_cnt + 4'd1;
                end
            end else begin
                hsync.pixel_valid <= 1'b0;
                hsync.HPIXEL      <= '0;
                sub_cnt           <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hsync_monitor.sv
// ---------------------------------------------------------------------------
// tb_hsync_monitor
//   Drives VGA_HSYNC line by line and compares every cycle's outputs with a
//   line-level reference model: strobes are the pin delayed by 3 cycles, the
//   period and width are differences of cycle numbers, and the pixel column
//   is a plain division of the offset into the line.
// ---------------------------------------------------------------------------
module tb_hsync_monitor;
    localparam int LINE  = 1600;
    localparam int PULSE = 192;
    localparam int BP    = 96;
    localparam int DISP  = 1280;
    localparam int CPP   = 10;
    localparam int TOL   = 2;
    localparam int LOCKN = 4;
    localparam int WIN_S = PULSE + BP;
    localparam int WIN_E = PULSE + BP + DISP - 1;
    localparam int TMO   = LINE + TOL + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hsync_if bus ();

    hsync_monitor dut (
        .clk   (clk),
        .reset (rst),
        .hsync (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_SEARCH, M_MEASURE, M_LOCKED} mode_t;

    mode_t    m_mode      = M_SEARCH;
    int       m_good      = 0;
    int       m_last_fall = 0;
    int       m_pw        = 0;
    bit       m_rise_seen = 1'b0;
    bit [4:0] pin_hist    = '1;   // [0] = pin this cycle, [4] = 4 cycles ago
    int       now         = 0;

    bit e_locked = 1'b0;
    bit e_valid  = 1'b0;
    bit e_err    = 1'b0;
    int e_hpix   = 0;
    int e_period = 0;
    int e_pw     = 0;

    int since, k, d_per, d_pw;
    bit fall, rise, good;

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pin_hist    = '1;
            m_mode      = M_SEARCH;
            m_good      = 0;
            m_rise_seen = 1'b0;
            m_pw        = 0;
            m_last_fall = now;
            e_locked    = 1'b0;
            e_valid     = 1'b0;
            e_err       = 1'b0;
            e_hpix      = 0;
            e_period    = 0;
            e_pw        = 0;
        end else begin
            pin_hist = {pin_hist[3:0], bus.VGA_HSYNC};
            fall     = pin_hist[4] && !pin_hist[3];
            rise     = !pin_hist[4] && pin_hist[3];
            since    = now - m_last_fall;
            e_err    = 1'b0;
            if (fall) begin
                if (m_mode == M_SEARCH) begin
                    m_mode = M_MEASURE;
                end else begin
                    d_per    = since - LINE;
                    d_pw     = m_pw - PULSE;
                    good     = m_rise_seen && d_per >= -TOL && d_per <= TOL
                               && d_pw >= -TOL && d_pw <= TOL;
                    e_period = clip(since, 2047);
                    e_pw     = clip(m_pw, 2047);
                    if (good) begin
                        if (m_mode == M_MEASURE) begin
                            m_good++;
                            if (m_good == LOCKN) m_mode = M_LOCKED;
                        end
                    end else begin
                        m_good = 0;
                        m_mode = M_MEASURE;
                        e_err  = 1'b1;
                    end
                end
                m_last_fall = now;
                m_rise_seen = 1'b0;
            end else begin
                if (rise && !m_rise_seen) begin
                    m_pw        = clip(since, 4095);
                    m_rise_seen = 1'b1;
                end
                if (m_mode != M_SEARCH && since == TMO) begin
                    e_err  = 1'b1;
                    m_mode = M_SEARCH;
                    m_good = 0;
                end
            end
            e_locked = (m_mode == M_LOCKED);
            k        = now + 1 - m_last_fall;
            e_valid  = e_locked && k >= WIN_S && k <= WIN_E;
            e_hpix   = e_valid ? (k - WIN_S) / CPP : 0;
        end
        now++;
    end

    always @(negedge clk) begin
        check("locked",      32'(bus.locked),      32'(e_locked));
        check("pixel_valid", 32'(bus.pixel_valid), 32'(e_valid));
        check("HPIXEL",      32'(bus.HPIXEL),      e_hpix);
        check("sync_error",  32'(bus.sync_error),  32'(e_err));
        check("line_period", 32'(bus.line_period), e_period);
        check("pulse_width", 32'(bus.pulse_width), e_pw);
    end

    // ---------------- stimulus ----------------
    // Called just after a posedge; fall-to-fall spacing is exactly p cycles.
    task automatic send_line(input int p, input int w);
        #1 bus.VGA_HSYNC = 1'b0;
        repeat (w) @(posedge clk);
        #1 bus.VGA_HSYNC = 1'b1;
        repeat (p - w) @(posedge clk);
    endtask

    task automatic nominal_lines(input int n);
        for (int i = 0; i < n; i++)
            send_line(LINE - TOL + int'($urandom_range(0, 2 * TOL)),
                      PULSE - TOL + int'($urandom_range(0, 2 * TOL)));
    endtask

    initial begin
        bus.VGA_HSYNC = 1'b1;
        #2 rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);

        nominal_lines(6);                 // lock after the 5th edge

        send_line(LINE - TOL, PULSE);     // 1598 keeps lock
        send_line(LINE - TOL - 1, PULSE); // 1597 drops lock at its end
        nominal_lines(5);                 // relock after 4 good lines

        send_line(LINE, PULSE + 3);       // width 195 is rejected
        nominal_lines(5);

        send_line(1000, PULSE);           // short line cuts the pixel window
        for (int i = 0; i < 8; i++)
            send_line(LINE - 6 + int'($urandom_range(0, 12)),
                      PULSE - 4 + int'($urandom_range(0, 8)));

        nominal_lines(5);                 // then sync stuck high: timeout
        repeat (1700) @(posedge clk);

        nominal_lines(5);                 // relock from SEARCH
        #1 bus.VGA_HSYNC = 1'b0;          // partial line, reset mid-display
        repeat (PULSE) @(posedge clk);
        #1 bus.VGA_HSYNC = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_locked",      32'(bus.locked),      32'd0);
        check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("rst_HPIXEL",      32'(bus.HPIXEL),      32'd0);
        check("rst_sync_error",  32'(bus.sync_error),  32'd0);
        check("rst_line_period", 32'(bus.line_period), 32'd0);
        check("rst_pulse_width", 32'(bus.pulse_width), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(posedge clk);

        nominal_lines(6);                 // full relock after reset
        repeat (50) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
